// File: rtl/boruss_mem_arbiter.sv
// Three-port arbiter for the shared single-port 8-bit memory: IF (0), data (1), debug/loader (2).
// Latency: ack one cycle after edge E0+MEM_WAIT+1; one access per MEM_WAIT+3 cycles.
// Backpressure: requesters hold req until ack. BORUSS_ARB_FIXED_PRIO_EN selects fixed priority 2>1>0.
module boruss_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MEM_WAIT = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [2:0]            req_i,
    input  logic [2:0]            we_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            ack_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [2:0]            grant_o,
    output logic                  busy_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              win_vld;
    logic [1:0]        win_idx;

`ifdef BORUSS_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b1;
        win_idx = 2'd0;
        if (req_i[2])      win_idx = 2'd2;
        else if (req_i[1]) win_idx = 2'd1;
        else if (req_i[0]) win_idx = 2'd0;
        else               win_vld = 1'b0;
    end
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Scan farthest candidate first so the one nearest rr_ptr overwrites and wins.
    always_comb begin
        logic [2:0] idx;
        win_vld = 1'b0;
        win_idx = 2'd0;
        idx     = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (req_i[idx[1:0]]) begin
                win_vld = 1'b1;
                win_idx = idx[1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_DONE) begin
            case (grant_q)
                3'b001:  rr_ptr_d = 2'd1;
                3'b010:  rr_ptr_d = 2'd2;
                default: rr_ptr_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rr_ptr_q <= 2'd0;
        else           rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d     = 3'b001 << win_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_i[win_idx];
                    mem_addr_d  = addr_i[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata_i[win_idx*DATA_W +: DATA_W];
                    cnt_d       = 4'(MEM_WAIT);
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!mem_we_q) rdata_d = mem_rdata_i;
                    ack_d    = grant_q;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                ack_d   = 3'b000;
                grant_d = 3'b000;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d    = 3'b000;
                grant_d  = 3'b000;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'b000;
            ack_q       <= 3'b000;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
